ifetch_unit: RTL and testbench

Instruction-fetch front end that feeds the multi-cycle control FSM. It holds the PC and issues one request per instruction to instruction memory. It captures the returned word, then presents it with instr_valid. While no instruction is held, it asserts stall toward the control FSM. It also accepts PC redirects from the execute stage for branch and jal/jalr, and counts fetched instructions.

---
 rtl/ifetch_unit_pkg.sv | 19 +
 rtl/ifetch_unit_if.sv | 13 +
 rtl/ifetch_timeout_ctr.sv | 29 ++
 rtl/ifetch_unit.sv | 141 ++++++++++++++
 tb/tb_ifetch_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);

endinterface

// File: rtl/ifetch_timeout_ctr.sv
// Loadable down-counter; expire pulses on the last permitted WAIT cycle.
module ifetch_timeout_ctr #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [7:0] count_r;

  // Count remaining WAIT cycles; reloaded on every issued request
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= 8'(MAX_WAIT - 1);
    end else if (en && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en && (count_r == 8'd0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: one imem request per instruction, holds the
// returned word for the control FSM and accepts branch/jump redirects.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     MAX_WAIT = 15,
  parameter logic [XLEN-1:0] NOP_WORD = ifetch_unit_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  ifetch_unit_if.master   imem,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic            stall,
  output logic            fetch_err,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] instr_r;
  logic            instr_valid_r;
  logic            fetch_err_r;
  logic [XLEN-1:0] fetch_count_r;
  logic            imem_req_r;
  logic [XLEN-1:0] imem_addr_r;
  logic            redir_pend_r;
  logic [XLEN-1:0] redir_pc_r;

  logic            expire_s;
  logic [XLEN-1:0] redir_now_s;
  logic            pend_now_s;
  logic [XLEN-1:0] pend_tgt_s;

  // A redirect arriving in the same cycle as the response is the newest target
  assign redir_now_s = pc_align(redirect_pc);
  assign pend_now_s  = redir_pend_r | redirect_valid;
  assign pend_tgt_s  = redirect_valid ? redir_now_s : redir_pc_r;

  ifetch_timeout_ctr #(.MAX_WAIT(MAX_WAIT)) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .load   (state_r == ST_REQ),
    .en     (state_r == ST_WAIT),
    .expire (expire_s)
  );

  // Fetch FSM with all outputs registered
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= NOP_WORD;
      instr_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
      fetch_count_r <= 32'd0;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= 32'd0;
      redir_pend_r  <= 1'b0;
      redir_pc_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_REQ;
          imem_req_r <= 1'b1;
          if (redirect_valid) begin
            pc_r        <= redir_now_s;
            imem_addr_r <= redir_now_s;
          end else begin
            imem_addr_r <= pc_r;
          end
        end
        ST_REQ: begin
          state_r    <= ST_WAIT;
          imem_req_r <= 1'b0;
          // The request is already issued, so its response must be dropped
          if (redirect_valid) begin
            pc_r         <= redir_now_s;
            redir_pend_r <= 1'b1;
            redir_pc_r   <= redir_now_s;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rvalid || expire_s) begin
            if (!imem.imem_rvalid) begin
              fetch_err_r <= 1'b1;
            end
            if (pend_now_s) begin
              state_r      <= ST_REQ;
              pc_r         <= pend_tgt_s;
              imem_req_r   <= 1'b1;
              imem_addr_r  <= pend_tgt_s;
              redir_pend_r <= 1'b0;
            end else begin
              state_r       <= ST_HOLD;
              instr_r       <= imem.imem_rvalid ? imem.imem_rdata : NOP_WORD;
              instr_valid_r <= 1'b1;
              fetch_count_r <= fetch_count_r + 32'd1;
            end
          end else if (redirect_valid) begin
            redir_pend_r <= 1'b1;
            redir_pc_r   <= redir_now_s;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            state_r       <= ST_REQ;
            pc_r          <= redir_now_s;
            imem_req_r    <= 1'b1;
            imem_addr_r   <= redir_now_s;
            instr_valid_r <= 1'b0;
          end else if (advance) begin
            state_r       <= ST_REQ;
            pc_r          <= pc_r + 32'd4;
            imem_req_r    <= 1'b1;
            imem_addr_r   <= pc_r + 32'd4;
            instr_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr          = instr_r;
  assign instr_valid    = instr_valid_r;
  assign pc             = pc_r;
  assign stall          = (state_r != ST_HOLD);
  assign fetch_err      = fetch_err_r;
  assign fetch_count    = fetch_count_r;
  assign imem.imem_req  = imem_req_r;
  assign imem.imem_addr = imem_addr_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios then randomized
// transactions checked against a transaction-level outcome model.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        advance = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] instr, pc, fetch_count;
  logic        instr_valid, stall, fetch_err;

  ifetch_unit_if imem_bus ();

  ifetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(MW), .NOP_WORD(32'h0000_0013)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .stall          (stall),
    .fetch_err      (fetch_err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_idle();
    advance = 1'b0;
    redirect_valid = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = $urandom();
  endtask

  // One request: response after 'delay' WAIT cycles (beyond MW means never),
  // optional redirect at WAIT cycle redir_at (0 = during REQ, -1 = none).
  task automatic run_fetch(input int delay, input int redir_at, input logic [31:0] tgt,
                           input logic [31:0] word, output bit refetch, output int req_wait);
    int end_k;
    bit tmo;
    bit redir;
    req_wait = 0;
    refetch = 1'b0;
    do begin
      @(negedge clk);
      drive_idle();
      req_wait++;
    end while (imem_bus.imem_req !== 1'b1 && req_wait < 6);
    chk("req_seen", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("req_addr", imem_bus.imem_addr, exp_pc);
    chk("req_stall", {31'd0, stall}, 32'd1);
    chk("req_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("req_count", fetch_count, exp_count);
    chk("req_err", {31'd0, fetch_err}, {31'd0, exp_err});
    end_k = (delay < MW) ? delay : MW;
    tmo   = (delay > MW);
    redir = (redir_at >= 0) && (redir_at <= end_k);
    advance = 1'($urandom_range(0, 1));
    if (redir_at == 0) begin
      redirect_valid = 1'b1;
      redirect_pc = tgt;
    end
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      drive_idle();
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
      advance = 1'($urandom_range(0, 1));
      if (k == delay) begin
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata = word;
      end
      if (k == redir_at) begin
        redirect_valid = 1'b1;
        redirect_pc = tgt;
      end
    end
    if (tmo) exp_err = 1'b1;
    if (redir) begin
      exp_pc = {tgt[31:2], 2'b00};
      refetch = 1'b1;
    end else begin
      @(negedge clk);
      drive_idle();
      exp_count++;
      chk("hold_instr", instr, tmo ? 32'h0000_0013 : word);
      chk("hold_ivalid", {31'd0, instr_valid}, 32'd1);
      chk("hold_stall", {31'd0, stall}, 32'd0);
      chk("hold_count", fetch_count, exp_count);
      chk("hold_err", {31'd0, fetch_err}, {31'd0, exp_err});
      chk("hold_pc", pc, exp_pc);
    end
  endtask

  // Stay in HOLD for 'idle' cycles, then release with advance and/or redirect
  task automatic leave_hold(input int idle, input bit adv, input bit rv, input logic [31:0] tgt);
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      drive_idle();
      chk("keep_ivalid", {31'd0, instr_valid}, 32'd1);
      chk("keep_stall", {31'd0, stall}, 32'd0);
      chk("keep_pc", pc, exp_pc);
    end
    advance = adv;
    redirect_valid = rv;
    redirect_pc = tgt;
    if (rv) exp_pc = {tgt[31:2], 2'b00};
    else if (adv) exp_pc = exp_pc + 32'd4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rf;
    int          rw;
    int          mode;
    int          dly;
    int          rat;
    int          tries;
    logic [31:0] tgt;

    drive_idle();
    exp_pc = 32'd0;
    exp_count = 32'd0;
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_addr", imem_bus.imem_addr, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // First fetch: REQ one cycle after release, word held two cycles later
    rstn = 1'b0;
    run_fetch(1, -1, 32'd0, 32'h0050_0093, rf, rw);
    chk("first_req_latency", rw, 32'd1);

    leave_hold(1, 1'b1, 1'b0, 32'd0);
    run_fetch(2, -1, 32'd0, mem_word(exp_pc), rf, rw);

    // Redirect beats advance and drops the low address bits
    leave_hold(0, 1'b1, 1'b1, 32'h0000_0103);
    run_fetch(1, -1, 32'd0, mem_word(exp_pc), rf, rw);

    // Redirect in WAIT discards the late response
    leave_hold(0, 1'b1, 1'b0, 32'd0);
    run_fetch(3, 1, 32'h0000_0040, 32'hDEAD_BEEF, rf, rw);
    run_fetch(1, -1, 32'd0, mem_word(exp_pc), rf, rw);

    // Timeout delivers NOP and sets the sticky error
    leave_hold(0, 1'b1, 1'b0, 32'd0);
    run_fetch(MW + 20, -1, 32'd0, 32'd0, rf, rw);
    leave_hold(0, 1'b1, 1'b0, 32'd0);
    run_fetch(2, -1, 32'd0, mem_word(exp_pc), rf, rw);

    // PC wraps from the top word to zero
    leave_hold(0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_fetch(1, -1, 32'd0, mem_word(exp_pc), rf, rw);
    leave_hold(0, 1'b1, 1'b0, 32'd0);
    run_fetch(1, -1, 32'd0, mem_word(exp_pc), rf, rw);

    // Reset in WAIT, then a stray response in IDLE
    leave_hold(0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd1);
    chk("midrst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_err", {31'd0, fetch_err}, 32'd0);
    chk("midrst_count", fetch_count, 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'hBAD0_BAD0;
    exp_pc = 32'd0;
    exp_count = 32'd0;
    exp_err = 1'b0;
    run_fetch(1, -1, 32'd0, mem_word(exp_pc), rf, rw);
    chk("postrst_req_latency", rw, 32'd1);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      tgt = $urandom();
      leave_hold($urandom_range(0, 2), mode != 1, mode != 0, tgt);
      tries = 0;
      do begin
        dly = $urandom_range(1, MW + 3);
        rat = -1;
        if (tries < 3 && $urandom_range(0, 3) == 0)
          rat = $urandom_range(0, (dly < MW) ? dly : MW);
        run_fetch(dly, rat, $urandom(), mem_word(exp_pc), rf, rw);
        tries++;
      end while (rf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
